// File: rtl/wb_write_arbiter.sv
// Writeback merge for the register file: two 2-entry producer FIFOs,
// round-robin selection, registered write port and pending-write bitmap.

// Two-entry FIFO with 1-bit pointers; exposes its slots for the pending map.
module wb_write_fifo #(
    parameter int W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [W-1:0]        din,
    output logic [W-1:0]        head,
    output logic [1:0][W-1:0]   slot,
    output logic [1:0]          slot_vld,
    output logic [1:0]          count
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        cnt_q, cnt_d;

    // Next-state: write at wptr, advance pointers, track occupancy.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wptr_q] = din;
            wptr_d        = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State register; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Which physical slots currently hold live entries.
    always_comb begin
        slot_vld = 2'b00;
        case (cnt_q)
            2'd2:    slot_vld = 2'b11;
            2'd1:    slot_vld[rptr_q] = 1'b1;
            default: slot_vld = 2'b00;
        endcase
    end

    assign head  = mem_q[rptr_q];
    assign slot  = mem_q;
    assign count = cnt_q;

endmodule

module wb_write_arbiter #(
    parameter  int N          = 8,
    parameter  int M          = 4,
    parameter  int DISCARD_R0 = 1,
    localparam int A          = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [A-1:0] alu_addr,
    input  logic [N-1:0] alu_data,
    input  logic         mem_valid,
    output logic         mem_ready,
    input  logic [A-1:0] mem_addr,
    input  logic [N-1:0] mem_data,
    output logic         we,
    output logic [A-1:0] waddr,
    output logic [N-1:0] wdata,
    output logic [M-1:0] pending
);

    localparam int W = A + N;

    logic [W-1:0]      alu_head, mem_head;
    logic [1:0][W-1:0] alu_slot, mem_slot;
    logic [1:0]        alu_vld, mem_vld;
    logic [1:0]        alu_cnt, mem_cnt;
    logic              alu_push, mem_push;
    logic              gnt_alu, gnt_mem;

    logic              last_mem_q, last_mem_d;
    logic              we_q, we_d;
    logic [A-1:0]      waddr_q, waddr_d;
    logic [N-1:0]      wdata_q, wdata_d;

    logic [W-1:0]      head;
    logic [A-1:0]      head_addr;
    logic              discard;
    logic [M-1:0]      pending_c;

    // Ready is a function of occupancy only, held low during reset.
    assign alu_ready = !rst && (alu_cnt != 2'd2);
    assign mem_ready = !rst && (mem_cnt != 2'd2);
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    wb_write_fifo #(.W(W)) u_alu_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (alu_push),
        .pop      (gnt_alu),
        .din      ({alu_addr, alu_data}),
        .head     (alu_head),
        .slot     (alu_slot),
        .slot_vld (alu_vld),
        .count    (alu_cnt)
    );

    wb_write_fifo #(.W(W)) u_mem_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mem_push),
        .pop      (gnt_mem),
        .din      ({mem_addr, mem_data}),
        .head     (mem_head),
        .slot     (mem_slot),
        .slot_vld (mem_vld),
        .count    (mem_cnt)
    );

    // Round-robin grant: on a tie the source not granted last wins.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if ((alu_cnt != 2'd0) && ((mem_cnt == 2'd0) || last_mem_q)) begin
            gnt_alu = 1'b1;
        end else if (mem_cnt != 2'd0) begin
            gnt_mem = 1'b1;
        end
    end

    // Output stage next-state: load popped head, suppress we for r0.
    always_comb begin
        head       = gnt_alu ? alu_head : mem_head;
        head_addr  = head[W-1:N];
        discard    = (DISCARD_R0 != 0) && (head_addr == '0);
        last_mem_d = last_mem_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (gnt_alu || gnt_mem) begin
            last_mem_d = gnt_mem;
            we_d       = !discard;
            waddr_d    = head_addr;
            wdata_d    = head[N-1:0];
        end
    end

    // Write port and arbitration pointer; reset favours the ALU first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_mem_q <= 1'b1;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            last_mem_q <= last_mem_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Pending map: live FIFO slots plus the write currently on the port.
    always_comb begin
        pending_c = '0;
        for (int r = 0; r < M; r++) begin
            for (int s = 0; s < 2; s++) begin
                if (alu_vld[s] && (alu_slot[s][W-1:N] == A'(r))) begin
                    pending_c[r] = 1'b1;
                end
                if (mem_vld[s] && (mem_slot[s][W-1:N] == A'(r))) begin
                    pending_c[r] = 1'b1;
                end
            end
            if (we_q && (waddr_q == A'(r))) begin
                pending_c[r] = 1'b1;
            end
        end
        if (DISCARD_R0 != 0) begin
            pending_c[0] = 1'b0;
        end
    end

    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign pending = pending_c;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with a queue-based reference
// model and an in-order scoreboard of issued register writes.
module tb_wb_write_arbiter;

    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alu_valid = 1'b0;
    logic       alu_ready;
    logic [1:0] alu_addr = '0;
    logic [7:0] alu_data = '0;
    logic       mem_valid = 1'b0;
    logic       mem_ready;
    logic [1:0] mem_addr = '0;
    logic [7:0] mem_data = '0;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    ent_t mq_a[$];
    ent_t mq_m[$];
    ent_t sb[$];
    bit         last_mem = 1'b1;
    bit         exp_we = 1'b0;
    logic [1:0] exp_waddr = '0;
    logic [7:0] exp_wdata = '0;

    wb_write_arbiter #(.N(8), .M(4), .DISCARD_R0(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_pending();
        logic [3:0] p;
        p = '0;
        foreach (mq_a[i]) if (mq_a[i].a != 0) p[mq_a[i].a] = 1'b1;
        foreach (mq_m[i]) if (mq_m[i].a != 0) p[mq_m[i].a] = 1'b1;
        if (exp_we) p[exp_waddr] = 1'b1;
        return p;
    endfunction

    // Scoreboard: every issued write must match the oldest expected one.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {22'd0, waddr, wdata}, 32'hFFFF);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("sb_waddr", waddr, e.a);
                chk("sb_wdata", wdata, e.d);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        @(posedge clk);
        #1;
        mq_a.delete();
        mq_m.delete();
        sb.delete();
        last_mem = 1'b1;
        exp_we = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pending", pending, 0);
        rst = 1'b0;
    endtask

    task automatic step(input bit av, input logic [1:0] aa,
                        input logic [7:0] ad, input bit mv,
                        input logic [1:0] ma, input logic [7:0] md);
        bit   acc_a, acc_m, popped;
        ent_t e;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        #1;
        chk("alu_ready", alu_ready, mq_a.size() < 2);
        chk("mem_ready", mem_ready, mq_m.size() < 2);
        acc_a = av && (mq_a.size() < 2);
        acc_m = mv && (mq_m.size() < 2);
        @(posedge clk);
        #1;
        popped = 1'b0;
        if (mq_a.size() > 0 && (mq_m.size() == 0 || last_mem)) begin
            e = mq_a.pop_front();
            last_mem = 1'b0;
            popped = 1'b1;
        end else if (mq_m.size() > 0) begin
            e = mq_m.pop_front();
            last_mem = 1'b1;
            popped = 1'b1;
        end
        exp_we = 1'b0;
        if (popped) begin
            exp_waddr = e.a;
            exp_wdata = e.d;
            exp_we = (e.a != 0);
            if (exp_we) sb.push_back(e);
        end
        if (acc_a) begin
            e.a = aa;
            e.d = ad;
            mq_a.push_back(e);
        end
        if (acc_m) begin
            e.a = ma;
            e.d = md;
            mq_m.push_back(e);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("we", we, exp_we);
        chk("waddr", waddr, exp_waddr);
        chk("wdata", wdata, exp_wdata);
        chk("pending", pending, model_pending());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();

        // Single ALU write, latency and pending lifetime.
        step(1, 2'd2, 8'hA5, 0, 0, 0);
        chk("t1_pend_c1", pending, 4'b0100);
        chk("t1_we_c1", we, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_we_c2", we, 1);
        chk("t1_waddr_c2", waddr, 2);
        chk("t1_wdata_c2", wdata, 8'hA5);
        chk("t1_pend_c2", pending, 4'b0100);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_pend_c3", pending, 4'b0000);
        chk("t1_hold_wdata", wdata, 8'hA5);

        // Dual traffic every cycle: alternating grants.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 2'd1, 8'h10 + 8'(i), 1, 2'd3, 8'h20 + 8'(i));
        idle(4);
        chk("t2_drained", sb.size(), 0);

        // ALU FIFO fill while MEM holds priority.
        do_reset();
        step(1, 2'd1, 8'h31, 1, 2'd3, 8'h41);
        step(1, 2'd1, 8'h32, 1, 2'd3, 8'h42);
        step(1, 2'd1, 8'h33, 0, 0, 0);
        chk("t3_full_ready", alu_ready, 0);
        step(1, 2'd1, 8'h34, 0, 0, 0);
        idle(6);
        chk("t3_drained", sb.size(), 0);

        // Register 0 discard followed by a normal write.
        step(1, 2'd0, 8'h77, 0, 0, 0);
        chk("t4_pend0", pending[0], 0);
        step(1, 2'd1, 8'h78, 0, 0, 0);
        chk("t4_discard_we", we, 0);
        chk("t4_discard_wdata", wdata, 8'h77);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_next_we", we, 1);
        chk("t4_next_waddr", waddr, 1);
        idle(2);

        // Reset with writes queued in both FIFOs.
        step(1, 2'd1, 8'h51, 1, 2'd2, 8'h61);
        step(1, 2'd3, 8'h52, 1, 2'd2, 8'h62);
        step(1, 2'd1, 8'h53, 1, 2'd3, 8'h63);
        do_reset();
        chk("t5_pending", pending, 0);
        idle(6);

        // Sustained push+pop at count 1.
        step(1, 2'd2, 8'h80, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 2'd2, 8'h80 + 8'(i), 0, 0, 0);
            chk("t6_alu_ready", alu_ready, 1);
        end
        idle(3);
        chk("t6_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
